servo_pwm_capture: RTL



---
 rtl/servo_pwm_capture.sv | 136 +++++++++++++
 1 files changed

// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: measures servo PWM high time and period, validates them and decodes open/closed.
// Define SERVO_PWM_CAPTURE_FILTER_EN to insert a FILTER_LEN-sample glitch filter after the synchronizer.
module servo_pwm_capture #(
    parameter int CNT_W       = 20,
    parameter int PULSE_MIN   = 25_000,
    parameter int PULSE_MAX   = 50_000,
    parameter int PERIOD_MIN  = 450_000,
    parameter int PERIOD_MAX  = 550_000,
    parameter int OPEN_THRESH = 37_500,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             err,
    output logic             open_pos,
    output logic             signal_lost
);
    localparam logic [1:0] IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2;
    localparam logic [CNT_W-1:0] C_PU_MIN  = CNT_W'(PULSE_MIN);
    localparam logic [CNT_W-1:0] C_PU_MAX  = CNT_W'(PULSE_MAX);
    localparam logic [CNT_W-1:0] C_PER_MIN = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] C_PER_MAX = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] C_OPEN    = CNT_W'(OPEN_THRESH);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    logic [1:0]       r_sync;
    logic             r_s_d;
    logic             w_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hi, r_per, r_hi_lat;
    logic [CNT_W-1:0] r_width, r_period;
    logic             r_valid, r_err, r_open, r_lost;
    logic             w_rise, w_fall, w_to, w_ok;
    logic [CNT_W-1:0] w_hi_inc, w_per_inc;
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b00;
        else     r_sync <= {r_sync[0], pwm_in};
    end
`ifdef SERVO_PWM_CAPTURE_FILTER_EN
    // The level only flips once the newest FILTER_LEN samples all agree.
    logic [FILTER_LEN-2:0] r_flt;
    logic [FILTER_LEN-1:0] w_win;
    logic                  r_s;
    assign w_win = {r_flt, r_sync[1]};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flt <= '0;
            r_s   <= 1'b0;
        end else begin
            r_flt <= w_win[FILTER_LEN-2:0];
            if (&w_win)       r_s <= 1'b1;
            else if (~|w_win) r_s <= 1'b0;
        end
    end
    assign w_s = r_s;
`else
    assign w_s = r_sync[1];
`endif
    assign w_rise    = w_s & ~r_s_d;
    assign w_fall    = ~w_s & r_s_d;
    assign w_hi_inc  = (r_hi  >= C_PER_MAX) ? r_hi  : r_hi  + C_ONE;
    assign w_per_inc = (r_per >= C_PER_MAX) ? r_per : r_per + C_ONE;
    // A rise arriving on the timeout cycle still closes the frame normally.
    assign w_to = (r_state != IDLE) && (r_per >= C_PER_MAX) && !w_rise;
    assign w_ok = (r_hi_lat >= C_PU_MIN) && (r_hi_lat <= C_PU_MAX) &&
                  (r_per >= C_PER_MIN) && (r_per <= C_PER_MAX);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_d    <= 1'b0;
            r_state  <= IDLE;
            r_hi     <= '0;
            r_per    <= '0;
            r_hi_lat <= '0;
            r_width  <= '0;
            r_period <= '0;
            r_open   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_lost   <= 1'b1;
        end else begin
            r_s_d   <= w_s;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_to) begin
                r_state <= IDLE;
                r_hi    <= '0;
                r_per   <= '0;
                r_lost  <= 1'b1;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_hi  <= w_rise ? C_ONE : '0;
                        r_per <= w_rise ? C_ONE : '0;
                        if (w_rise) r_state <= HIGH;
                    end
                    HIGH: begin
                        r_hi  <= w_hi_inc;
                        r_per <= w_per_inc;
                        if (w_fall) begin
                            r_state  <= LOW;
                            r_hi_lat <= r_hi;
                        end
                    end
                    LOW: begin
                        r_per <= w_per_inc;
                        if (w_rise) begin
                            r_state <= HIGH;
                            r_hi    <= C_ONE;
                            r_per   <= C_ONE;
                            if (w_ok) begin
                                r_width  <= r_hi_lat;
                                r_period <= r_per;
                                r_open   <= r_hi_lat >= C_OPEN;
                                r_valid  <= 1'b1;
                                r_lost   <= 1'b0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign width       = r_width;
    assign period      = r_period;
    assign valid       = r_valid;
    assign err         = r_err;
    assign open_pos    = r_open;
    assign signal_lost = r_lost;
endmodule
